// File: rtl/pe_col_seq_ctrl_if.sv
// Job handshake bundle for the PE column sequencer, plus the shared weight-mode type.
// The master offers a job; the slave (sequencer) answers with ready and finish.
package pe_col_seq_pkg;
  typedef enum logic [2:0] {
    A_MODE = 3'd0,
    B_MODE = 3'd1,
    C_MODE = 3'd2,
    D_MODE = 3'd3,
    E_MODE = 3'd4
  } PE_weight_mode_t;
endpackage

interface pe_col_seq_ctrl_if #(
  parameter int NSLOT = 6
);
  logic             ctrl_valid;
  logic             ctrl_ready;
  logic             ctrl_finish;
  logic [NSLOT-1:0] guard_map_i;
  logic             bit_mode_i;
  logic             kernel_mode_i;
  logic             is_odd_row_i;
  logic             end_of_row_i;

  modport master (
    output ctrl_valid, guard_map_i, bit_mode_i, kernel_mode_i, is_odd_row_i, end_of_row_i,
    input  ctrl_ready, ctrl_finish
  );

  modport slave (
    input  ctrl_valid, guard_map_i, bit_mode_i, kernel_mode_i, is_odd_row_i, end_of_row_i,
    output ctrl_ready, ctrl_finish
  );
endinterface

// File: rtl/pe_col_seq_ctrl.sv
// PE column sequencer: walks the set slots of a job's guard map MSB first, one per
// unstalled cycle, accepting the next job on the last slot so jobs run back to back.
module pe_col_seq_ctrl
  import pe_col_seq_pkg::*;
#(
  parameter int NSLOT  = 6,
  parameter int NSTALL = 1,
  parameter int SW     = $clog2(NSLOT)
) (
  input  logic              clk,
  input  logic              rst_n,
  pe_col_seq_ctrl_if.slave  ctrl,
  input  logic [NSTALL-1:0] stall_i,
  output logic [SW-1:0]     slot_o,
  output PE_weight_mode_t   weight_mode_o,
  output logic              bit_mode_o,
  output logic              end_of_row_o,
  output logic              activation_en_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic [NSLOT-1:0] map_q, map_d;
  logic             kernel_q, kernel_d;
  logic             odd_q, odd_d;
  logic             bm_q, bm_d;
  logic             eor_q, eor_d;
  PE_weight_mode_t  wm_q, wm_d;

  logic             stall_s;
  logic             run_s;
  logic             last_s;
  logic             ready_s;
  logic             accept_s;
  logic             empty_s;
  logic             finish_s;
  logic [NSLOT-1:0] eff_map_s;
  logic [NSLOT-1:0] lower_s;

  function automatic logic [SW-1:0] top_slot(input logic [NSLOT-1:0] m);
    logic [SW-1:0] idx;
    idx = {SW{1'b0}};
    for (int i = 0; i < NSLOT; i++) begin
      idx = m[i] ? SW'(i) : idx;
    end
    return idx;
  endfunction

  // Ordinal k counts from the MSB slot (k=1); its parity picks the mode pair.
  function automatic PE_weight_mode_t slot_mode(input logic run, input logic [SW-1:0] s,
                                                input logic kern, input logic odd);
    logic [31:0] k;
    PE_weight_mode_t m;
    k = 32'(NSLOT) - 32'(s);
    if (!run || !kern) begin
      m = E_MODE;
    end else if (k[0]) begin
      m = odd ? A_MODE : C_MODE;
    end else begin
      m = odd ? B_MODE : D_MODE;
    end
    return m;
  endfunction

  // Handshake decode; last means no set map bit remains below the current slot.
  always_comb begin
    stall_s   = |stall_i;
    eff_map_s = ctrl.bit_mode_i ? {NSLOT{1'b1}} : ctrl.guard_map_i;
    lower_s   = map_q & ((NSLOT'(1'b1) << slot_q) - NSLOT'(1'b1));
    run_s     = (state_q == ST_RUN);
    last_s    = run_s && (lower_s == {NSLOT{1'b0}});
    ready_s   = !stall_s && (!run_s || last_s);
    accept_s  = ctrl.ctrl_valid && ready_s;
    empty_s   = (eff_map_s == {NSLOT{1'b0}});
    finish_s  = !stall_s && (last_s || (accept_s && empty_s));
  end

  // Next-state: stall holds everything, accept reloads, otherwise step or retire.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    map_d    = map_q;
    kernel_d = kernel_q;
    odd_d    = odd_q;
    bm_d     = bm_q;
    eor_d    = eor_q;
    if (stall_s) begin
      state_d = state_q;
    end else if (accept_s) begin
      map_d    = eff_map_s;
      kernel_d = ctrl.kernel_mode_i;
      odd_d    = ctrl.is_odd_row_i;
      bm_d     = ctrl.bit_mode_i;
      eor_d    = ctrl.end_of_row_i;
      if (empty_s) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_RUN;
        slot_d  = top_slot(eff_map_s);
      end
    end else if (run_s && !last_s) begin
      slot_d = top_slot(lower_s);
    end else if (run_s) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_q;
    end
    wm_d = slot_mode(state_d == ST_RUN, slot_d, kernel_d, odd_d);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      slot_q   <= {SW{1'b0}};
      map_q    <= {NSLOT{1'b0}};
      kernel_q <= 1'b0;
      odd_q    <= 1'b0;
      bm_q     <= 1'b0;
      eor_q    <= 1'b0;
      wm_q     <= E_MODE;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      map_q    <= map_d;
      kernel_q <= kernel_d;
      odd_q    <= odd_d;
      bm_q     <= bm_d;
      eor_q    <= eor_d;
      wm_q     <= wm_d;
    end
  end

  assign ctrl.ctrl_ready  = ready_s;
  assign ctrl.ctrl_finish = finish_s;
  assign slot_o           = slot_q;
  assign weight_mode_o    = wm_q;
  assign bit_mode_o       = bm_q;
  assign end_of_row_o     = eor_q;
  assign activation_en_o  = run_s && !stall_s;

endmodule

// File: tb/tb_pe_col_seq_ctrl.sv
// Randomised and directed bench for pe_col_seq_ctrl, checked against a queue-based
// model that holds the list of slots still to be issued for the current job.
module tb_pe_col_seq_ctrl;
  import pe_col_seq_pkg::*;

  localparam int NSLOT  = 6;
  localparam int NSTALL = 2;
  localparam int SW     = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NSTALL-1:0] stall;
  logic [SW-1:0]     slot;
  PE_weight_mode_t   wm;
  logic              bm_o, eor_o, act_o;

  pe_col_seq_ctrl_if #(.NSLOT(NSLOT)) cif();

  pe_col_seq_ctrl #(.NSLOT(NSLOT), .NSTALL(NSTALL), .SW(SW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ctrl            (cif),
    .stall_i         (stall),
    .slot_o          (slot),
    .weight_mode_o   (wm),
    .bit_mode_o      (bm_o),
    .end_of_row_o    (eor_o),
    .activation_en_o (act_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int obs_act  = 0;
  int obs_fin  = 0;
  bit acc_last = 1'b0;

  // Reference: remaining slots of the running job, plus captured flags.
  int q[$];
  bit k_m, o_m, bm_m, eor_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic PE_weight_mode_t exp_mode(input bit run, input int s, input bit kern, input bit odd);
    int k;
    k = NSLOT - s;
    if (!run || !kern) return E_MODE;
    if (k % 2 == 1) return odd ? A_MODE : C_MODE;
    return odd ? B_MODE : D_MODE;
  endfunction

  // One cycle: inputs are already set at the falling edge; compare, advance model.
  task automatic step();
    bit st, run, last, rdy, acc, fin, act;
    logic [NSLOT-1:0] eff;
    int cur;
    #1;
    st   = |stall;
    eff  = cif.bit_mode_i ? {NSLOT{1'b1}} : cif.guard_map_i;
    run  = q.size() > 0;
    last = q.size() == 1;
    cur  = run ? q[0] : 0;
    rdy  = !st && (!run || last);
    acc  = cif.ctrl_valid && rdy;
    fin  = !st && ((run && last) || (acc && eff == '0));
    act  = run && !st;
    chk("ready", cif.ctrl_ready, rdy);
    chk("finish", cif.ctrl_finish, fin);
    chk("act_en", act_o, act);
    chk("bit_mode_o", bm_o, bm_m);
    chk("end_of_row_o", eor_o, eor_m);
    chk("weight_mode", wm, exp_mode(run, cur, k_m, o_m));
    if (run) chk("slot", slot, cur);
    if (act_o === 1'b1) obs_act++;
    if (cif.ctrl_finish === 1'b1) obs_fin++;
    if (!st) begin
      if (run) void'(q.pop_front());
      if (acc) begin
        k_m = cif.kernel_mode_i; o_m = cif.is_odd_row_i;
        bm_m = cif.bit_mode_i; eor_m = cif.end_of_row_i;
        q.delete();
        for (int i = NSLOT - 1; i >= 0; i--) if (eff[i]) q.push_back(i);
      end
    end
    acc_last = acc;
    @(negedge clk);
  endtask

  task automatic drive_job(input logic [NSLOT-1:0] m, input bit bmode, input bit kmode,
                           input bit odd, input bit eor);
    int n;
    cif.guard_map_i = m; cif.bit_mode_i = bmode; cif.kernel_mode_i = kmode;
    cif.is_odd_row_i = odd; cif.end_of_row_i = eor; cif.ctrl_valid = 1'b1;
    acc_last = 1'b0;
    n = 0;
    while (!acc_last && n < 40) begin
      step();
      n++;
    end
    if (!acc_last) chk("accept_timeout", 32'd0, 32'd1);
    cif.ctrl_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_slot"}, slot, 32'd0);
    chk({tag, "_act"}, act_o, 32'd0);
    chk({tag, "_fin"}, cif.ctrl_finish, 32'd0);
    chk({tag, "_wm"}, wm, E_MODE);
    chk({tag, "_bm"}, bm_o, 32'd0);
    chk({tag, "_eor"}, eor_o, 32'd0);
    chk({tag, "_ready"}, cif.ctrl_ready, 32'd1);
  endtask

  initial begin
    int a0, f0;
    rst_n = 1'b0; stall = '0;
    cif.ctrl_valid = 1'b0; cif.guard_map_i = '0; cif.bit_mode_i = 1'b0;
    cif.kernel_mode_i = 1'b0; cif.is_odd_row_i = 1'b0; cif.end_of_row_i = 1'b0;
    k_m = 0; o_m = 0; bm_m = 0; eor_m = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Sparse map, odd row: slots 5,3,0 with A,A,B.
    a0 = obs_act; f0 = obs_fin;
    drive_job(6'b101001, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (4) step();
    chk("sparse_act_cycles", obs_act - a0, 32'd3);
    chk("sparse_finishes", obs_fin - f0, 32'd1);

    // Empty job finishes on accept and never runs.
    a0 = obs_act; f0 = obs_fin;
    drive_job(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    chk("empty_act_cycles", obs_act - a0, 32'd0);
    chk("empty_finishes", obs_fin - f0, 32'd1);

    // 4-bit mode forces a dense map.
    a0 = obs_act;
    drive_job(6'b000000, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (7) step();
    chk("dense_act_cycles", obs_act - a0, 32'd6);
    chk("dense_bit_mode_o", bm_o, 32'd1);

    // Back-to-back jobs with no bubble.
    a0 = obs_act; f0 = obs_fin;
    drive_job(6'b110000, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_job(6'b000011, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) step();
    chk("b2b_act_cycles", obs_act - a0, 32'd4);
    chk("b2b_finishes", obs_fin - f0, 32'd2);

    // Stall on the last slot defers finish.
    drive_job(6'b100001, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    f0 = obs_fin;
    stall = 2'b10;
    repeat (3) step();
    chk("stall_no_finish", obs_fin - f0, 32'd0);
    stall = 2'b00;
    step();
    chk("finish_after_release", obs_fin - f0, 32'd1);
    repeat (2) step();

    // Asynchronous reset while slot 3 is issued.
    drive_job(6'b111111, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    step();
    chk("pre_reset_slot", slot, 32'd3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midjob_reset");
    q.delete(); k_m = 0; o_m = 0; bm_m = 0; eor_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    a0 = obs_act;
    drive_job(6'b010000, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) step();
    chk("post_reset_act_cycles", obs_act - a0, 32'd1);

    // Random traffic with random stalls.
    for (int c = 0; c < 600; c++) begin
      stall = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      if (!cif.ctrl_valid && $urandom_range(0, 3) != 0) begin
        cif.guard_map_i   = ($urandom_range(0, 4) == 0) ? 6'b000000 : 6'($urandom_range(0, 63));
        cif.bit_mode_i    = ($urandom_range(0, 5) == 0);
        cif.kernel_mode_i = 1'($urandom_range(0, 1));
        cif.is_odd_row_i  = 1'($urandom_range(0, 1));
        cif.end_of_row_i  = 1'($urandom_range(0, 1));
        cif.ctrl_valid    = 1'b1;
      end
      step();
      if (acc_last) cif.ctrl_valid = 1'b0;
    end
    stall = '0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
